mem_write_monitor: RTL and testbench

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

---
 rtl/mem_write_monitor_pkg.sv | 18 +
 rtl/mem_write_monitor_if.sv | 25 ++
 rtl/mem_write_monitor_table.sv | 61 ++++++
 rtl/mem_write_monitor.sv | 155 +++++++++++++++
 tb/tb_mem_write_monitor.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_write_monitor_pkg.sv
// Shared types for the memory write monitor: FSM state encoding and fail codes.
package mem_write_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISMATCH = 2'd1,
        FC_TIMEOUT  = 2'd2,
        FC_RSVD     = 2'd3
    } fail_code_t;

endpackage

// File: rtl/mem_write_monitor_if.sv
// Load channel and observed write bus of the memory write monitor.
//   master: testbench / environment side, drives entries and DUT writes
//   slave : monitor side, returns load_ready
interface mem_write_monitor_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          mem_write;
    logic [AW-1:0] adr;
    logic [DW-1:0] write_data;

    modport master (
        output load_valid, load_addr, load_data, mem_write, adr, write_data,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_addr, load_data, mem_write, adr, write_data,
        output load_ready
    );
endinterface

// File: rtl/mem_write_monitor_table.sv
// Expected-write register file: entries are appended in load order and
// consumed in the same order through a separate read pointer.
//   flush    : empties the table (count and read pointer to 0)
//   wr_en    : append wr_entry at the next free slot (ignored when full)
//   rd_rewind: read pointer back to the first entry
//   rd_adv   : step to the next expected entry
//   rd_entry_c / rd_last_c: current expected entry and "it is the final one"
module mem_write_monitor_table #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_entry,
    input  logic          rd_rewind,
    input  logic          rd_adv,
    output logic [W-1:0]  rd_entry_c,
    output logic          rd_last_c,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic          do_wr;

    assign do_wr = wr_en && !flush && (count < CW'(DEPTH));

    // Storage needs no reset: an empty table is defined by count alone.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[PW'(count)] <= wr_entry;
        end
    end

    // Entry count doubles as the write pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            count    <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                count <= count + CW'(1);
            end
            if (rd_rewind) begin
                rd_ptr_q <= '0;
            end else if (rd_adv) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign rd_entry_c = mem[rd_ptr_q];
    assign rd_last_c  = (CW'(rd_ptr_q) + CW'(1)) == count;

endmodule

// File: rtl/mem_write_monitor.sv
// Checks a DUT's memory writes against an in-order list of expected
// (address, data) pairs. Writes inside the ignore window that do not match
// are skipped; any other unexpected write, or too long without a match,
// ends the run in FAIL. PASS/FAIL are sticky until clear or reset.
//   clk, reset : clock, async active-high reset
//   clear      : synchronous flush back to IDLE
//   start      : begin checking (needs at least one loaded entry)
//   bus        : load channel + observed write bus (slave side)
//   busy/pass/fail/fail_code/match_count/fail_addr/fail_data : status
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned IGN_LO  = 96,
    parameter int unsigned IGN_HI  = 96,
    parameter int unsigned TIMEOUT = 4096,
    localparam int unsigned MCW    = $clog2(DEPTH + 1),
    localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    mem_write_monitor_if.slave    bus,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [1:0]            fail_code,
    output logic [MCW-1:0]        match_count,
    output logic [AW-1:0]         fail_addr,
    output logic [DW-1:0]         fail_data
);
    state_t         state_q, state_d;
    fail_code_t     fc_q, fc_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [MCW-1:0] mc_d, cnt, cnt_next;
    logic [AW-1:0]  fa_d;
    logic [DW-1:0]  fd_d;
    logic           flush, wr_en, rd_rewind, rd_adv, rd_last_c;
    logic           hit, in_ign;
    logic [AW+DW-1:0] rd_entry_c;

    mem_write_monitor_table #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_entry   ({bus.load_addr, bus.load_data}),
        .rd_rewind  (rd_rewind),
        .rd_adv     (rd_adv),
        .rd_entry_c (rd_entry_c),
        .rd_last_c  (rd_last_c),
        .count      (cnt)
    );

    assign hit    = bus.mem_write
                 && (bus.adr == rd_entry_c[AW+DW-1:DW])
                 && (bus.write_data == rd_entry_c[DW-1:0]);
    assign in_ign = (bus.adr >= AW'(IGN_LO)) && (bus.adr <= AW'(IGN_HI));

    // Next state, table control and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mc_d      = match_count;
        fc_d      = fc_q;
        fa_d      = fail_addr;
        fd_d      = fail_data;
        flush     = 1'b0;
        wr_en     = 1'b0;
        rd_rewind = 1'b0;
        rd_adv    = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
            timer_d = '0;
            mc_d    = '0;
            fc_d    = FC_NONE;
            fa_d    = '0;
            fd_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_en = bus.load_valid && bus.load_ready;
                    if (start && (cnt != '0)) begin
                        state_d   = ST_RUN;
                        rd_rewind = 1'b1;
                        timer_d   = '0;
                        mc_d      = '0;
                    end
                end
                ST_RUN: begin
                    // Expected-entry match beats both the ignore window and timeout.
                    if (hit) begin
                        rd_adv  = 1'b1;
                        mc_d    = match_count + MCW'(1);
                        timer_d = '0;
                        if (rd_last_c) begin
                            state_d = ST_PASS;
                        end
                    end else if (bus.mem_write && !in_ign) begin
                        state_d = ST_FAIL;
                        fc_d    = FC_MISMATCH;
                        fa_d    = bus.adr;
                        fd_d    = bus.write_data;
                    end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                        state_d = ST_FAIL;
                        fc_d    = FC_TIMEOUT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_next = flush ? '0 : (cnt + MCW'(wr_en));

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            match_count    <= '0;
            fc_q           <= FC_NONE;
            fail_addr      <= '0;
            fail_data      <= '0;
            busy           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            bus.load_ready <= 1'b1;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            match_count    <= mc_d;
            fc_q           <= fc_d;
            fail_addr      <= fa_d;
            fail_data      <= fd_d;
            busy           <= (state_d == ST_RUN);
            pass           <= (state_d == ST_PASS);
            fail           <= (state_d == ST_FAIL);
            bus.load_ready <= (state_d == ST_IDLE) && (cnt_next < MCW'(DEPTH));
        end
    end

    assign fail_code = fc_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
module tb_mem_write_monitor;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk, reset, clear, start;
    logic busy, pass, fail;
    logic [1:0]    fail_code;
    logic [3:0]    match_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    int checks = 0;
    int passes = 0;

    logic [31:0] ea [8];
    logic [31:0] ed [8];

    mem_write_monitor_if #(.AW(AW), .DW(DW)) bus ();

    mem_write_monitor #(
        .DW(DW), .AW(AW), .DEPTH(8), .IGN_LO(96), .IGN_HI(96), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .bus(bus),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_count(match_count), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic load_entry(input logic [31:0] a, input logic [31:0] d);
        bus.load_valid = 1'b1; bus.load_addr = a; bus.load_data = d;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.mem_write = 1'b1; bus.adr = a; bus.write_data = d;
        tick();
        bus.mem_write = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if ({busy, pass, fail} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, pass, fail}); else passes++;
        checks++; if (fail_code !== 2'd0 || match_count !== 4'd0) $display("FAIL reset_code_cnt: got %0d/%0d want 0/0", fail_code, match_count); else passes++;
        checks++; if (fail_addr !== 32'd0 || fail_data !== 32'd0) $display("FAIL reset_capture: got %h/%h want 0/0", fail_addr, fail_data); else passes++;
        checks++; if (bus.load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b want 1", bus.load_ready); else passes++;
    endtask

    task automatic test_basic();
        load_entry(32'd100, 32'd25);
        do_start();
        checks++; if (busy !== 1'b1 || bus.load_ready !== 1'b0) $display("FAIL basic_run: busy %b ready %b want 1 0", busy, bus.load_ready); else passes++;
        do_write(32'd96, 32'd7);
        checks++; if (busy !== 1'b1 || fail !== 1'b0) $display("FAIL basic_ignore: busy %b fail %b want 1 0", busy, fail); else passes++;
        do_write(32'd100, 32'd25);
        checks++; if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pass: pass %b fail %b busy %b want 1 0 0", pass, fail, busy); else passes++;
        checks++; if (match_count !== 4'd1) $display("FAIL basic_count: got %0d want 1", match_count); else passes++;
        // PASS is sticky: mismatching write, start and load are ignored.
        do_write(32'd104, 32'd0);
        do_start();
        checks++; if (pass !== 1'b1 || fail !== 1'b0 || bus.load_ready !== 1'b0) $display("FAIL pass_sticky: pass %b fail %b ready %b want 1 0 0", pass, fail, bus.load_ready); else passes++;
    endtask

    task automatic test_mismatch();
        do_clear();
        checks++; if (pass !== 1'b0 || match_count !== 4'd0 || bus.load_ready !== 1'b1) $display("FAIL clear_pass: pass %b cnt %0d ready %b want 0 0 1", pass, match_count, bus.load_ready); else passes++;
        load_entry(32'd100, 32'd25);
        do_start();
        do_write(32'd104, 32'd25);
        checks++; if (fail !== 1'b1 || fail_code !== 2'd1 || busy !== 1'b0) $display("FAIL mismatch_flag: fail %b code %0d busy %b want 1 1 0", fail, fail_code, busy); else passes++;
        checks++; if (fail_addr !== 32'd104 || fail_data !== 32'd25) $display("FAIL mismatch_capture: got %0d/%0d want 104/25", fail_addr, fail_data); else passes++;
        do_write(32'd100, 32'd25);
        checks++; if (fail !== 1'b1 || pass !== 1'b0 || fail_addr !== 32'd104) $display("FAIL fail_sticky: fail %b pass %b addr %0d want 1 0 104", fail, pass, fail_addr); else passes++;
    endtask

    task automatic test_timeout();
        do_clear();
        checks++; if (fail !== 1'b0 || fail_code !== 2'd0) $display("FAIL clear_fail: fail %b code %0d want 0 0", fail, fail_code); else passes++;
        load_entry(32'd200, 32'd1);
        do_start();
        repeat (15) tick();
        checks++; if (fail !== 1'b0 || busy !== 1'b1) $display("FAIL timeout_early: fail %b busy %b want 0 1 after 15 cycles", fail, busy); else passes++;
        tick();
        checks++; if (fail !== 1'b1 || fail_code !== 2'd2) $display("FAIL timeout_fire: fail %b code %0d want 1 2 after 16 cycles", fail, fail_code); else passes++;
    endtask

    task automatic test_timer_boundary();
        do_clear();
        load_entry(32'd300, 32'd11);
        load_entry(32'd304, 32'd22);
        do_start();
        repeat (15) tick();
        do_write(32'd300, 32'd11);
        checks++; if (fail !== 1'b0 || match_count !== 4'd1) $display("FAIL timer_match_wins: fail %b cnt %0d want 0 1", fail, match_count); else passes++;
        repeat (14) tick();
        do_write(32'd96, 32'd0);
        do_write(32'd304, 32'd22);
        checks++; if (pass !== 1'b1 || match_count !== 4'd2) $display("FAIL timer_restart: pass %b cnt %0d want 1 2", pass, match_count); else passes++;
    endtask

    task automatic test_full();
        do_clear();
        for (int i = 0; i < 9; i++) begin
            bus.load_valid = 1'b1;
            bus.load_addr  = 32'h200 + 32'(i) * 32'd4;
            bus.load_data  = 32'(i) * 32'd3 + 32'd1;
            checks++; if (bus.load_ready !== (i < 8)) $display("FAIL full_ready_%0d: got %b want %b", i, bus.load_ready, (i < 8)); else passes++;
            tick();
        end
        bus.load_valid = 1'b0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            do_write(32'h200 + 32'(i) * 32'd4, 32'(i) * 32'd3 + 32'd1);
            checks++; if (match_count !== 4'(i + 1)) $display("FAIL full_count_%0d: got %0d want %0d", i, match_count, i + 1); else passes++;
        end
        checks++; if (pass !== 1'b1 || fail !== 1'b0) $display("FAIL full_pass: pass %b fail %b want 1 0", pass, fail); else passes++;
    endtask

    task automatic test_ignore_window();
        do_clear();
        load_entry(32'd96, 32'd5);
        do_start();
        do_write(32'd96, 32'd3);
        checks++; if (busy !== 1'b1 || fail !== 1'b0 || match_count !== 4'd0) $display("FAIL ign_skip: busy %b fail %b cnt %0d want 1 0 0", busy, fail, match_count); else passes++;
        do_write(32'd96, 32'd5);
        checks++; if (pass !== 1'b1 || match_count !== 4'd1) $display("FAIL ign_match: pass %b cnt %0d want 1 1", pass, match_count); else passes++;
    endtask

    task automatic test_clear_priority();
        do_clear();
        load_entry(32'd400, 32'd9);
        clear = 1'b1; start = 1'b1;
        bus.load_valid = 1'b1; bus.load_addr = 32'd404; bus.load_data = 32'd9;
        tick();
        clear = 1'b0; start = 1'b0; bus.load_valid = 1'b0;
        checks++; if (busy !== 1'b0 || bus.load_ready !== 1'b1) $display("FAIL clear_prio: busy %b ready %b want 0 1", busy, bus.load_ready); else passes++;
        do_start();
        checks++; if (busy !== 1'b0) $display("FAIL start_empty: busy %b want 0", busy); else passes++;
    endtask

    task automatic test_reset_mid_run();
        do_clear();
        load_entry(32'd500, 32'd1);
        load_entry(32'd504, 32'd2);
        load_entry(32'd508, 32'd3);
        do_start();
        do_write(32'd500, 32'd1);
        do_write(32'd504, 32'd2);
        checks++; if (match_count !== 4'd2 || busy !== 1'b1) $display("FAIL pre_reset: cnt %0d busy %b want 2 1", match_count, busy); else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, pass, fail} !== 3'b000 || match_count !== 4'd0 || fail_code !== 2'd0) $display("FAIL async_reset: flags %b cnt %0d code %0d want 000 0 0", {busy, pass, fail}, match_count, fail_code); else passes++;
        checks++; if (bus.load_ready !== 1'b1) $display("FAIL async_reset_ready: got %b want 1", bus.load_ready); else passes++;
        #2 reset = 1'b0;
        tick();
        do_start();
        checks++; if (busy !== 1'b0) $display("FAIL start_after_reset: busy %b want 0", busy); else passes++;
    endtask

    // Random in-order scenarios; the expected outcome comes from walking the
    // expected list: each entry is matched in turn, or a planted bad write ends it.
    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int n, bad_at, exp_mc;
            logic [31:0] ba, bd;
            do_clear();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                ea[k] = ($urandom & 32'h7FFF_FFF0) | 32'h1000;
                ed[k] = $urandom;
                load_entry(ea[k], ed[k]);
            end
            do_start();
            bad_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : n;
            exp_mc = 0;
            for (int k = 0; k < n; k++) begin
                int gaps;
                gaps = $urandom_range(0, 5);
                for (int g = 0; g < gaps; g++) begin
                    if ($urandom_range(0, 1) == 1) do_write(32'd96, $urandom);
                    else tick();
                end
                checks++; if (busy !== 1'b1 || fail !== 1'b0) $display("FAIL rnd_gap_%0d_%0d: busy %b fail %b want 1 0", it, k, busy, fail); else passes++;
                if (k == bad_at) begin
                    if ($urandom_range(0, 1) == 1) begin ba = ea[k] + 32'd4; bd = ed[k]; end
                    else begin ba = ea[k]; bd = ed[k] ^ 32'h1; end
                    do_write(ba, bd);
                    checks++; if (fail !== 1'b1 || fail_code !== 2'd1 || match_count !== 4'(exp_mc)) $display("FAIL rnd_bad_%0d: fail %b code %0d cnt %0d want 1 1 %0d", it, fail, fail_code, match_count, exp_mc); else passes++;
                    checks++; if (fail_addr !== ba || fail_data !== bd) $display("FAIL rnd_capture_%0d: got %h/%h want %h/%h", it, fail_addr, fail_data, ba, bd); else passes++;
                    break;
                end
                do_write(ea[k], ed[k]);
                exp_mc++;
                checks++; if (match_count !== 4'(exp_mc) || pass !== (k == n - 1)) $display("FAIL rnd_match_%0d_%0d: cnt %0d pass %b want %0d %b", it, k, match_count, pass, exp_mc, (k == n - 1)); else passes++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0;
        bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.mem_write = 1'b0; bus.adr = '0; bus.write_data = '0;
        #12;
        test_reset();
        reset = 1'b0;
        tick();
        test_basic();
        test_mismatch();
        test_timeout();
        test_timer_boundary();
        test_full();
        test_ignore_window();
        test_clear_priority();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
